trap_ctrl: RTL

- Sequences every trap and trap-return for the core. It sits between the pipeline's exception detectors and the CSR file, and drives fetch redirection.
- Captures and prioritises one exception per event and pulses the matching CSR exception input for exactly one cycle.
- Holds the pipeline (stall plus flush), then hands the fetch stage a redirect PC (mtvec on trap, mepc on MRET) through a valid/ready handshake.
- Drains a programmable number of cycles before releasing the pipeline.

---
 rtl/trap_ctrl_pkg.sv | 43 ++++
 rtl/trap_ctrl_if.sv | 27 ++
 rtl/trap_ctrl_prio_enc.sv | 38 +++
 rtl/trap_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the trap sequencer:
//   - state_e        : 2-bit FSM encoding (IDLE=0, CAPTURE=1, REDIRECT=2, DRAIN=3)
//   - CAUSE_*        : one-hot cause constants. Bit 0 has the highest priority:
//                      inst_addr > illegal > ebreak > ecall > ld_addr > st_addr
//   - csr_pulse_sel  : maps a one-hot cause onto the four CSR pulse lines.
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_DRAIN    = 2'd3
    } state_e;

    localparam int NUM_CAUSE = 6;

    // Bit position equals priority rank (bit 0 wins).
    localparam logic [NUM_CAUSE-1:0] CAUSE_NONE      = 6'b000000;
    localparam logic [NUM_CAUSE-1:0] CAUSE_INST_ADDR = 6'b000001;
    localparam logic [NUM_CAUSE-1:0] CAUSE_ILLEGAL   = 6'b000010;
    localparam logic [NUM_CAUSE-1:0] CAUSE_EBREAK    = 6'b000100;
    localparam logic [NUM_CAUSE-1:0] CAUSE_ECALL     = 6'b001000;
    localparam logic [NUM_CAUSE-1:0] CAUSE_LD_ADDR   = 6'b010000;
    localparam logic [NUM_CAUSE-1:0] CAUSE_ST_ADDR   = 6'b100000;

    // Returns {st_addr, ld_addr, illegal, inst_addr} pulse lines.
    // ECALL/EBREAK map to no pulse: the CSR file records those causes itself.
    function automatic logic [3:0] csr_pulse_sel(input logic [NUM_CAUSE-1:0] cause);
        logic [3:0] sel;
        case (cause)
            CAUSE_INST_ADDR: sel = 4'b0001;
            CAUSE_ILLEGAL:   sel = 4'b0010;
            CAUSE_LD_ADDR:   sel = 4'b0100;
            CAUSE_ST_ADDR:   sel = 4'b1000;
            default:         sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// ---------------------------------------------------------------------------
// trap_ctrl_if
// Fetch-redirect valid/ready handshake between the trap sequencer and fetch.
//   o_redirect_valid : redirect PC is valid        (trap_ctrl -> fetch)
//   o_redirect_pc    : new fetch PC, XLEN bits      (trap_ctrl -> fetch)
//   i_redirect_ready : fetch accepts the redirect   (fetch -> trap_ctrl)
// Modports: master = trap_ctrl side, slave = fetch side.
// ---------------------------------------------------------------------------
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;
    logic            i_redirect_ready;

    modport master (
        output o_redirect_valid,
        output o_redirect_pc,
        input  i_redirect_ready
    );

    modport slave (
        input  o_redirect_valid,
        input  o_redirect_pc,
        output i_redirect_ready
    );
endinterface

// File: rtl/trap_ctrl_prio_enc.sv
// ---------------------------------------------------------------------------
// trap_prio_enc
// Combinational fixed-priority encoder for the six exception requests.
//   i_req    : request vector, bit 0 highest priority
//              {st_addr, ld_addr, ecall, ebreak, illegal, inst_addr}
//   o_cause  : one-hot winning cause (CAUSE_NONE when idle)
//   o_any_ex : at least one request is active
// ---------------------------------------------------------------------------
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic [NUM_CAUSE-1:0] i_req,
    output logic [NUM_CAUSE-1:0] o_cause,
    output logic                 o_any_ex
);

    // Pick the lowest-indexed (highest-priority) active request.
    always_comb begin
        o_cause  = CAUSE_NONE;
        o_any_ex = |i_req;
        if (i_req[0]) begin
            o_cause = CAUSE_INST_ADDR;
        end else if (i_req[1]) begin
            o_cause = CAUSE_ILLEGAL;
        end else if (i_req[2]) begin
            o_cause = CAUSE_EBREAK;
        end else if (i_req[3]) begin
            o_cause = CAUSE_ECALL;
        end else if (i_req[4]) begin
            o_cause = CAUSE_LD_ADDR;
        end else if (i_req[5]) begin
            o_cause = CAUSE_ST_ADDR;
        end else begin
            o_cause = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Sequences traps and MRET returns: captures and prioritises one exception,
// pulses the matching CSR exception line for one cycle, stalls/flushes the
// pipeline, hands fetch a redirect PC (mtvec on trap, mepc on MRET) over a
// valid/ready handshake, then drains DRAIN_CYCLES cycles before releasing.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_ex_* / i_ebreak /
//   i_ecall / i_mret        : exception and return requests (sampled in IDLE)
//   i_pc, i_badaddr         : faulting PC / address, latched with the event
//   i_tvec, i_epc           : mtvec / mepc from the CSR file
//   o_csr_ex*               : one-cycle cause pulses to the CSR file
//   o_csr_pc, o_csr_badaddr : latched PC / address for mepc / mtval
//   o_stall, o_flush, o_busy: pipeline control, high whenever not IDLE
//   redir                   : redirect handshake (trap_ctrl_if.master)
// All outputs are registered.
// ---------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_illegal,
    input  logic            i_ebreak,
    input  logic            i_ecall,
    input  logic            i_ex_ld_addr,
    input  logic            i_ex_st_addr,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_badaddr,
    input  logic [XLEN-1:0] i_tvec,
    input  logic [XLEN-1:0] i_epc,
    output logic            o_csr_ex,
    output logic            o_csr_ex_inst_addr,
    output logic            o_csr_ex_ld_addr,
    output logic            o_csr_ex_st_addr,
    output logic [XLEN-1:0] o_csr_pc,
    output logic [XLEN-1:0] o_csr_badaddr,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_busy,
    trap_ctrl_if.master     redir
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_e                 state_r;
    state_e                 next_state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [XLEN-1:0]        target_r;
    logic [3:0]             pulse_r;
    logic                   stall_r;
    logic                   valid_r;
    logic [NUM_CAUSE-1:0]   req_s;
    logic [NUM_CAUSE-1:0]   cause_s;
    logic                   any_ex_s;
    logic                   take_ex_s;
    logic                   take_mret_s;

    assign req_s = {i_ex_st_addr, i_ex_ld_addr, i_ecall, i_ebreak,
                    i_ex_illegal, i_ex_inst_addr};

    trap_prio_enc u_prio_enc (
        .i_req    (req_s),
        .o_cause  (cause_s),
        .o_any_ex (any_ex_s)
    );

    // Requests only count in IDLE; an exception always beats a same-cycle MRET.
    assign take_ex_s   = (state_r == ST_IDLE) && any_ex_s;
    assign take_mret_s = (state_r == ST_IDLE) && !any_ex_s && i_mret;

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_ex_s) begin
                    next_state_s = ST_CAPTURE;
                end else if (i_mret) begin
                    next_state_s = ST_REDIRECT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                next_state_s = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redir.i_redirect_ready) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == CNT_ZERO) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and state-derived registered outputs (look-ahead on next state).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            stall_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            stall_r <= (next_state_s != ST_IDLE);
            valid_r <= (next_state_s == ST_REDIRECT);
        end
    end

    // CSR cause pulses: set on the edge entering CAPTURE, cleared on the next.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pulse_r <= 4'b0000;
        end else if (take_ex_s) begin
            pulse_r <= csr_pulse_sel(cause_s);
        end else begin
            pulse_r <= 4'b0000;
        end
    end

    // Latch faulting PC/address with the exception; held until the next trap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_csr_pc      <= {XLEN{1'b0}};
            o_csr_badaddr <= {XLEN{1'b0}};
        end else if (take_ex_s) begin
            o_csr_pc      <= i_pc;
            o_csr_badaddr <= i_badaddr;
        end else begin
            o_csr_pc      <= o_csr_pc;
            o_csr_badaddr <= o_csr_badaddr;
        end
    end

    // Redirect target: mepc on MRET, mtvec sampled in CAPTURE so a same-cycle
    // CSR write is seen. Never written in REDIRECT, so it stays stable there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            target_r <= {XLEN{1'b0}};
        end else if (take_mret_s) begin
            target_r <= i_epc;
        end else if (state_r == ST_CAPTURE) begin
            target_r <= i_tvec;
        end else begin
            target_r <= target_r;
        end
    end

    // Drain counter: loaded on redirect acceptance, counts down to zero in DRAIN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_REDIRECT) && redir.i_redirect_ready) begin
            cnt_r <= DRAIN_LOAD;
        end else if ((state_r == ST_DRAIN) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_csr_ex_inst_addr     = pulse_r[0];
    assign o_csr_ex               = pulse_r[1];
    assign o_csr_ex_ld_addr       = pulse_r[2];
    assign o_csr_ex_st_addr       = pulse_r[3];
    assign o_stall                = stall_r;
    assign o_flush                = stall_r;
    assign o_busy                 = stall_r;
    assign redir.o_redirect_valid = valid_r;
    assign redir.o_redirect_pc    = target_r;

endmodule
